// File: rtl/bag_pkg.sv
// rtl/bag_pkg.sv - shared types and constants for the bag randomizer
// Contents: shuffle/deal state enum, Galois LFSR tap mask, default seed,
// and the empty piece ID.
package bag_pkg;

    typedef enum logic [1:0] {
        SHUFFLE = 2'd0,
        FIXUP   = 2'd1,
        DEAL    = 2'd2
    } bag_state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          EMPTY_ID     = 0;

endpackage

// File: rtl/lfsr16_galois.sv
// rtl/lfsr16_galois.sv - 16-bit Galois LFSR with seed load
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state <= SEED)
//   load         one-cycle pulse, replaces this cycle's advance with load_val
//   load_val     new seed; zero is replaced by SEED so the LFSR never locks up
//   state        current LFSR state
import bag_pkg::*;

module lfsr16_galois #(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        if (load) begin
            state_d = (load_val == 16'h0000) ? SEED : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bag_randomizer.sv
// rtl/bag_randomizer.sv - N-piece bag randomizer with preview queue
// Build option: BAG_NO_REPEAT_EN adds a one-cycle FIXUP pass that stops the
// first piece of a bag from repeating the last piece of the previous bag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   seed_load    one-cycle pulse, loads seed_in into the LFSR (bag/queue kept)
//   seed_in      new seed; zero selects SEED
//   next_req     pop request; ignored while piece_valid is low
//   piece_valid  queue head holds a piece
//   piece_id     queue head (preview slot 0)
//   preview      slot k at [k*ID_W +: ID_W], empty slots read 0
//   bag_busy     shuffle (or fixup) in progress
import bag_pkg::*;

module bag_randomizer #(
    parameter int          NUM_PIECES    = 7,
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] SEED          = DEFAULT_SEED,
    parameter int          ID_W          = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          seed_load,
    input  logic [15:0]                   seed_in,
    input  logic                          next_req,
    output logic                          piece_valid,
    output logic [ID_W-1:0]               piece_id,
    output logic [PREVIEW_DEPTH*ID_W-1:0] preview,
    output logic                          bag_busy
);

    localparam int CNT_W = $clog2(PREVIEW_DEPTH + 1);

    bag_state_e      state_q, state_d;
    logic [ID_W-1:0] bag_q [NUM_PIECES];
    logic [ID_W-1:0] bag_d [NUM_PIECES];
    logic [ID_W-1:0] i_q, i_d;
    logic [ID_W-1:0] deal_idx_q, deal_idx_d;
    logic [ID_W-1:0] q_q [PREVIEW_DEPTH];
    logic [ID_W-1:0] q_d [PREVIEW_DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
`ifdef BAG_NO_REPEAT_EN
    logic [ID_W-1:0] last_id_q, last_id_d;
`endif

    logic [15:0]      lfsr_state;
    logic [7:0]       j_wide;
    logic [ID_W-1:0]  j;
    logic [ID_W-1:0]  bag_at_i, bag_at_j, bag_at_deal;
    logic [CNT_W-1:0] wr_idx;
    logic             pop, push;
    logic             unused_bits;

    lfsr16_galois #(
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    // Fisher-Yates pick: j in 0..i from the low LFSR byte.
    assign j_wide      = lfsr_state[7:0] % (8'(i_q) + 8'd1);
    assign j           = j_wide[ID_W-1:0];
    assign unused_bits = ^{lfsr_state[15:8], j_wide[7:ID_W]};

    // Compare-based read muxes keep index widths independent of NUM_PIECES.
    always_comb begin
        bag_at_i    = '0;
        bag_at_j    = '0;
        bag_at_deal = '0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            if (ID_W'(k) == i_q)        bag_at_i    = bag_q[k];
            if (ID_W'(k) == j)          bag_at_j    = bag_q[k];
            if (ID_W'(k) == deal_idx_q) bag_at_deal = bag_q[k];
        end
    end

    assign pop = next_req && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        deal_idx_d = deal_idx_q;
        bag_d      = bag_q;
        q_d        = q_q;
        count_d    = count_q;
        push       = 1'b0;
`ifdef BAG_NO_REPEAT_EN
        last_id_d  = last_id_q;
`endif

        case (state_q)
            SHUFFLE: begin
                // When i == j both writes carry the same value.
                for (int k = 0; k < NUM_PIECES; k++) begin
                    if (ID_W'(k) == j)   bag_d[k] = bag_at_i;
                    if (ID_W'(k) == i_q) bag_d[k] = bag_at_j;
                end
                i_d = i_q - ID_W'(1);
                if (i_q == ID_W'(1)) begin
`ifdef BAG_NO_REPEAT_EN
                    state_d = FIXUP;
`else
                    state_d = DEAL;
`endif
                end
            end
            FIXUP: begin
`ifdef BAG_NO_REPEAT_EN
                // last_id_q is zero for the first bag, which never matches.
                if (bag_q[0] == last_id_q) begin
                    bag_d[0]            = bag_q[NUM_PIECES-1];
                    bag_d[NUM_PIECES-1] = bag_q[0];
                end
`endif
                state_d = DEAL;
            end
            DEAL: begin
                push = (count_q < CNT_W'(PREVIEW_DEPTH)) || pop;
                if (push) begin
                    deal_idx_d = deal_idx_q + ID_W'(1);
                    if (deal_idx_q == ID_W'(NUM_PIECES - 1)) begin
                        deal_idx_d = '0;
                        i_d        = ID_W'(NUM_PIECES - 1);
                        state_d    = SHUFFLE;
`ifdef BAG_NO_REPEAT_EN
                        last_id_d  = bag_at_deal;
`endif
                    end
                end
            end
            default: begin
                state_d = SHUFFLE;
            end
        endcase

        // Shift toward the head first, then drop the new piece at the tail
        // position as it stands after the shift.
        if (pop) begin
            for (int k = 0; k < PREVIEW_DEPTH - 1; k++) begin
                q_d[k] = q_q[k+1];
            end
            q_d[PREVIEW_DEPTH-1] = ID_W'(EMPTY_ID);
        end
        wr_idx = pop ? (count_q - CNT_W'(1)) : count_q;
        if (push) begin
            for (int k = 0; k < PREVIEW_DEPTH; k++) begin
                if (CNT_W'(k) == wr_idx) q_d[k] = bag_at_deal;
            end
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHUFFLE;
            i_q        <= ID_W'(NUM_PIECES - 1);
            deal_idx_q <= '0;
            count_q    <= '0;
            for (int k = 0; k < NUM_PIECES; k++) begin
                bag_q[k] <= ID_W'(k + 1);
            end
            for (int k = 0; k < PREVIEW_DEPTH; k++) begin
                q_q[k] <= ID_W'(EMPTY_ID);
            end
`ifdef BAG_NO_REPEAT_EN
            last_id_q  <= ID_W'(EMPTY_ID);
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            deal_idx_q <= deal_idx_d;
            count_q    <= count_d;
            bag_q      <= bag_d;
            q_q        <= q_d;
`ifdef BAG_NO_REPEAT_EN
            last_id_q  <= last_id_d;
`endif
        end
    end

    always_comb begin
        preview = '0;
        for (int k = 0; k < PREVIEW_DEPTH; k++) begin
            preview[k*ID_W +: ID_W] = q_q[k];
        end
    end

    assign piece_valid = (count_q != '0);
    assign piece_id    = q_q[0];
    assign bag_busy    = (state_q != DEAL);

endmodule

// File: tb/tb_bag_randomizer.sv
// tb/tb_bag_randomizer.sv - randomized self-checking bench for bag_randomizer
module tb_bag_randomizer;

    localparam int          N    = 7;
    localparam int          PD   = 3;
    localparam int          IW   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BAG_NO_REPEAT_EN
    localparam int          NR   = 1;
`else
    localparam int          NR   = 0;
`endif

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b1;
    logic            seed_load = 1'b0;
    logic [15:0]     seed_in   = 16'h0;
    logic            next_req  = 1'b0;
    logic            piece_valid;
    logic [IW-1:0]   piece_id;
    logic [PD*IW-1:0] preview;
    logic            bag_busy;

    int vectors     = 0;
    int miscompares = 0;

    bag_randomizer #(
        .NUM_PIECES    (N),
        .PREVIEW_DEPTH (PD),
        .SEED          (SEED),
        .ID_W          (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .next_req    (next_req),
        .piece_valid (piece_valid),
        .piece_id    (piece_id),
        .preview     (preview),
        .bag_busy    (bag_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the bag as an int array, the preview queue as an SV
    // queue, phase 0 = shuffling, 1 = no-repeat fixup, 2 = dealing.
    logic [15:0] m_lfsr;
    int          m_bag [N];
    int          m_i, m_phase, m_d, m_last;
    int          m_q [$];
    int          dut_pops [$];

    function automatic void m_reset();
        m_lfsr = SEED;
        for (int k = 0; k < N; k++) m_bag[k] = k + 1;
        m_i     = N - 1;
        m_phase = 0;
        m_d     = 0;
        m_last  = 0;
        m_q.delete();
    endfunction

    task automatic m_step(input bit req, input bit ld, input logic [15:0] sin);
        logic [15:0] old;
        int j, t;
        old = m_lfsr;
        if (ld) m_lfsr = (sin != 16'h0) ? sin : SEED;
        else    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        if (req && m_q.size() > 0) void'(m_q.pop_front());
        case (m_phase)
            0: begin
                j = int'(old[7:0]) % (m_i + 1);
                t = m_bag[m_i]; m_bag[m_i] = m_bag[j]; m_bag[j] = t;
                m_i--;
                if (m_i == 0) m_phase = (NR != 0) ? 1 : 2;
            end
            1: begin
                if (m_bag[0] == m_last) begin
                    t = m_bag[0]; m_bag[0] = m_bag[N-1]; m_bag[N-1] = t;
                end
                m_phase = 2;
            end
            default: begin
                if (m_q.size() < PD) begin
                    m_q.push_back(m_bag[m_d]);
                    m_d++;
                    if (m_d == N) begin
                        m_last  = m_bag[N-1];
                        m_d     = 0;
                        m_i     = N - 1;
                        m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_outputs();
        logic [PD*IW-1:0] exp_prev;
        exp_prev = '0;
        for (int k = 0; k < m_q.size(); k++) exp_prev[k*IW +: IW] = IW'(m_q[k]);
        check("valid",   64'(piece_valid), 64'(m_q.size() > 0));
        check("head",    64'(piece_id),    64'((m_q.size() > 0) ? m_q[0] : 0));
        check("preview", 64'(preview),     64'(exp_prev));
        check("busy",    64'(bag_busy),    64'(m_phase != 2));
    endtask

    // Called at posedge+1; applies inputs for the next edge then checks.
    task automatic cycle(input bit req, input bit ld, input logic [15:0] sin);
        next_req  = req;
        seed_load = ld;
        seed_in   = sin;
        if (req && piece_valid) dut_pops.push_back(int'(piece_id));
        @(posedge clk);
        m_step(req, ld, sin);
        #1;
        compare_outputs();
    endtask

    task automatic rand_cycles(input int n, input int load_odds);
        bit req, ld;
        for (int c = 0; c < n; c++) begin
            req = ($urandom_range(0, 9) < 8);
            ld  = (load_odds > 0) && ($urandom_range(0, load_odds - 1) == 0);
            cycle(req, ld, 16'($urandom));
        end
    endtask

    // Asserts reset between edges and checks outputs before any edge.
    task automatic do_reset();
        next_req  = 1'b0;
        seed_load = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_valid",   64'(piece_valid), 64'(0));
        check("rst_id",      64'(piece_id),    64'(0));
        check("rst_preview", 64'(preview),     64'(0));
        check("rst_busy",    64'(bag_busy),    64'(1));
        @(posedge clk);
        #1;
        m_reset();
        dut_pops.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_groups(input string tag);
        logic [15:0] full;
        logic [15:0] mask;
        int groups;
        int v;
        full   = 16'((1 << (N + 1)) - 2);
        groups = dut_pops.size() / N;
        check({tag, "_groups"}, 64'(groups >= 2), 64'(1));
        for (int g = 0; g < groups; g++) begin
            mask = '0;
            for (int k = 0; k < N; k++) begin
                v = dut_pops[g*N + k];
                if (v >= 1 && v <= N) mask[v] = 1'b1;
            end
            check({tag, "_perm"}, 64'(mask), 64'(full));
`ifdef BAG_NO_REPEAT_EN
            if (g > 0) check({tag, "_boundary"}, 64'(dut_pops[g*N-1] != dut_pops[g*N]), 64'(1));
`endif
        end
    endtask

    initial begin
        int first;
        int drops;
        logic [IW-1:0] s0, s1, s2;

        #2;
        do_reset();

        first = 0;
        for (int e = 1; e <= 40 && first == 0; e++) begin
            cycle(1'b0, 1'b0, 16'h0);
            if (piece_valid) first = e;
        end
        check("first_valid_edge", 64'(first), 64'(N + NR));
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 16'h0);
        s0 = preview[0 +: IW];
        s1 = preview[IW +: IW];
        s2 = preview[2*IW +: IW];
        check("full_nonzero",  64'(s0 != 0 && s1 != 0 && s2 != 0), 64'(1));
        check("full_distinct", 64'(s0 != s1 && s1 != s2 && s0 != s2), 64'(1));

        drops = 0;
        for (int c = 0; c < 70; c++) begin
            cycle(1'b1, 1'b0, 16'h0);
            if (!piece_valid) drops++;
        end
        check("valid_drops", 64'(drops > 0), 64'(1));
        check_groups("hold");

        do_reset();
        for (int c = 0; c < N - 2; c++) cycle(1'b1, 1'b0, 16'h0);
        for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);

        do_reset();
        cycle(1'b0, 1'b1, 16'h1234);
        rand_cycles(80, 0);
        do_reset();
        cycle(1'b0, 1'b1, 16'h0000);
        rand_cycles(80, 0);

        do_reset();
        for (int c = 0; c < N + NR + 1; c++) cycle(1'b0, 1'b0, 16'h0);
        check("two_q_slot1", 64'(preview[IW +: IW] != 0), 64'(1));
        check("two_q_slot2", 64'(preview[2*IW +: IW]), 64'(0));
        do_reset();
        rand_cycles(60, 0);

        do_reset();
        rand_cycles(20000, 500);
        check("pop_volume", 64'(dut_pops.size() >= 5000), 64'(1));
        check_groups("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
